i2s_dac_tx: RTL

//  I2S transmitter for the DECA on-board audio codec, sitting between the guest core's 16-bit DAC_L/DAC_R

---
 rtl/i2s_pkg.sv | 15 +
 rtl/i2s_sample_fifo.sv | 63 ++++++
 rtl/i2s_dac_tx.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/i2s_pkg.sv
// Shared types and default sizing for the I2S DAC transmitter.
package i2s_pkg;

   localparam int DEF_DATA_BITS = 16;
   localparam int DEF_SLOT_BITS = 32;
   localparam int DEF_SCLK_DIV  = 16;
   localparam int DEF_MCLK_DIV  = 2;
   localparam int FRAME_BITS    = 2 * DEF_SLOT_BITS;

   typedef struct packed {
      logic [DEF_DATA_BITS-1:0] l;
      logic [DEF_DATA_BITS-1:0] r;
   } stereo_sample_t;

endpackage

// File: rtl/i2s_sample_fifo.sv
// Small stereo-sample FIFO feeding the I2S frame loader; head is visible whenever not empty.
module i2s_sample_fifo
   import i2s_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic           clk_i,
   input  logic           rst_ni,
   input  logic           push_i,
   input  stereo_sample_t push_data_i,
   input  logic           pop_i,
   output stereo_sample_t head_o,
   output logic           full_o,
   output logic           empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] COUNT_FULL = (AW+1)'(DEPTH);

   stereo_sample_t mem_q [DEPTH];
   logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [AW:0]    count_q, count_d;
   logic           do_push;
   logic           do_pop;

   assign full_o  = (count_q == COUNT_FULL);
   assign empty_o = (count_q == '0);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign head_o  = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Payload needs no reset: pointers and count define what is valid.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule

// File: rtl/i2s_dac_tx.sv
// Philips I2S transmitter: MCLK/SCLK/LRCK dividers, frame counter and bit shifters.
// Define I2S_TX_FIFO_EN for a FIFO_DEPTH-entry sample FIFO instead of a single holding register.
module i2s_dac_tx
   import i2s_pkg::*;
#(
   parameter int DATA_BITS  = DEF_DATA_BITS,
   parameter int SLOT_BITS  = DEF_SLOT_BITS,
   parameter int SCLK_DIV   = DEF_SCLK_DIV,
   parameter int MCLK_DIV   = DEF_MCLK_DIV,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clk_50MHz,
   input  logic                 reset_n,
   input  logic [DATA_BITS-1:0] l_data,
   input  logic [DATA_BITS-1:0] r_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic                 sample_req,
   output logic                 underrun,
   output logic                 dac_MCLK,
   output logic                 dac_SCLK,
   output logic                 dac_LRCK,
   output logic                 dac_SDIN
);

   localparam int FRAME_LEN = 2 * SLOT_BITS;
   localparam int MW = $clog2(MCLK_DIV);
   localparam int SW = $clog2(SCLK_DIV);
   localparam int BW = $clog2(FRAME_LEN);

   localparam logic [MW-1:0] MCLK_LAST  = MW'(MCLK_DIV - 1);
   localparam logic [MW-1:0] MCLK_HALF  = MW'(MCLK_DIV / 2);
   localparam logic [SW-1:0] SCLK_LAST  = SW'(SCLK_DIV - 1);
   localparam logic [SW-1:0] SCLK_HALF  = SW'(SCLK_DIV / 2);
   localparam logic [BW-1:0] BIT_LAST   = BW'(FRAME_LEN - 1);
   localparam logic [BW-1:0] SLOT_START = BW'(SLOT_BITS);
   localparam logic [BW-1:0] L_END      = BW'(DATA_BITS);
   localparam logic [BW-1:0] R_END      = BW'(SLOT_BITS + DATA_BITS);

   logic [MW-1:0]        mclk_cnt_q, mclk_cnt_d;
   logic [SW-1:0]        sclk_cnt_q, sclk_cnt_d;
   logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
   logic [BW-1:0]        bit_next;
   logic                 lrck_q, lrck_d;
   logic                 sdin_q, sdin_d;
   logic [DATA_BITS-1:0] shift_l_q, shift_l_d;
   logic [DATA_BITS-1:0] shift_r_q, shift_r_d;
   stereo_sample_t       last_q, last_d;

   stereo_sample_t       in_sample;
   stereo_sample_t       head;
   logic                 stor_empty;
   logic                 push;
   logic                 pop;
   logic                 bit_event;
   logic                 frame_load;

   assign in_sample.l = l_data;
   assign in_sample.r = r_data;

   assign bit_event  = (sclk_cnt_q == SCLK_LAST);
   assign frame_load = bit_event && (bit_cnt_q == BIT_LAST);
   assign bit_next   = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + 1'b1;
   assign push       = in_valid && in_ready;
   assign pop        = frame_load && !stor_empty;

`ifdef I2S_TX_FIFO_EN
   logic fifo_full;

   i2s_sample_fifo #(
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk_i       (clk_50MHz),
      .rst_ni      (reset_n),
      .push_i      (push),
      .push_data_i (in_sample),
      .pop_i       (pop),
      .head_o      (head),
      .full_o      (fifo_full),
      .empty_o     (stor_empty)
   );

   assign in_ready = !fifo_full;
`else
   logic           held_q, held_d;
   stereo_sample_t hold_q, hold_d;

   // in_ready is !held, so push and pop can never coincide here.
   always_comb begin
      held_d = held_q;
      hold_d = hold_q;
      if (pop) held_d = 1'b0;
      if (push) begin
         held_d = 1'b1;
         hold_d = in_sample;
      end
   end

   always_ff @(posedge clk_50MHz or negedge reset_n) begin
      if (!reset_n) begin
         held_q <= 1'b0;
         hold_q <= '0;
      end else begin
         held_q <= held_d;
         hold_q <= hold_d;
      end
   end

   assign stor_empty = !held_q;
   assign head       = hold_q;
   assign in_ready   = !held_q;
`endif

   always_comb begin
      mclk_cnt_d = (mclk_cnt_q == MCLK_LAST) ? '0 : mclk_cnt_q + 1'b1;
      sclk_cnt_d = (sclk_cnt_q == SCLK_LAST) ? '0 : sclk_cnt_q + 1'b1;
      bit_cnt_d  = bit_cnt_q;
      lrck_d     = lrck_q;
      sdin_d     = sdin_q;
      shift_l_d  = shift_l_q;
      shift_r_d  = shift_r_q;
      last_d     = last_q;
      if (bit_event) begin
         bit_cnt_d = bit_next;
         lrck_d    = (bit_next >= SLOT_START);
         sdin_d    = 1'b0;
         if (frame_load) begin
            // Empty storage replays the previous sample instead of going silent.
            if (!stor_empty) last_d = head;
            shift_l_d = stor_empty ? last_q.l : head.l;
            shift_r_d = stor_empty ? last_q.r : head.r;
         end else if (bit_next <= L_END) begin
            sdin_d    = shift_l_q[DATA_BITS-1];
            shift_l_d = {shift_l_q[DATA_BITS-2:0], 1'b0};
         end else if (bit_next > SLOT_START && bit_next <= R_END) begin
            sdin_d    = shift_r_q[DATA_BITS-1];
            shift_r_d = {shift_r_q[DATA_BITS-2:0], 1'b0};
         end
      end
   end

   // bit_cnt starts at its last value so the first bit event is a frame load.
   always_ff @(posedge clk_50MHz or negedge reset_n) begin
      if (!reset_n) begin
         mclk_cnt_q <= '0;
         sclk_cnt_q <= '0;
         bit_cnt_q  <= BIT_LAST;
         lrck_q     <= 1'b1;
         sdin_q     <= 1'b0;
         shift_l_q  <= '0;
         shift_r_q  <= '0;
         last_q     <= '0;
      end else begin
         mclk_cnt_q <= mclk_cnt_d;
         sclk_cnt_q <= sclk_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         lrck_q     <= lrck_d;
         sdin_q     <= sdin_d;
         shift_l_q  <= shift_l_d;
         shift_r_q  <= shift_r_d;
         last_q     <= last_d;
      end
   end

   assign dac_MCLK   = (mclk_cnt_q >= MCLK_HALF);
   assign dac_SCLK   = (sclk_cnt_q >= SCLK_HALF);
   assign dac_LRCK   = lrck_q;
   assign dac_SDIN   = sdin_q;
   assign sample_req = frame_load;
   assign underrun   = frame_load && stor_empty;

endmodule
